// File: rtl/mfu_logic.sv
// Registered multi-function bitwise logic unit: seven Boolean ops on a/b selected by sel, one-cycle latency.
// Optional accepted-operation counter enabled by defining MFU_OP_COUNT_EN.
module mfu_logic #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             err
`ifdef MFU_OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  logic [WIDTH-1:0] result_s;
  logic             err_s;
  logic [WIDTH-1:0] y_r;
  logic             out_valid_r;
  logic             err_r;

  // Opcode decode; reserved and unknown opcodes fall into the default branch
  always_comb begin
    result_s = {WIDTH{1'b0}};
    err_s    = 1'b0;
    case (sel)
      3'b000:  result_s = a & b;
      3'b001:  result_s = a | b;
      3'b010:  result_s = ~a;
      3'b011:  result_s = ~(a & b);
      3'b100:  result_s = ~(a | b);
      3'b101:  result_s = a ^ b;
      3'b110:  result_s = ~(a ^ b);
      default: begin
        result_s = {WIDTH{1'b0}};
        err_s    = 1'b1;
      end
    endcase
  end

  // Result register; y holds its value across idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (in_valid) begin
      y_r         <= result_s;
      out_valid_r <= 1'b1;
      err_r       <= err_s;
    end else begin
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end
  end

  assign y         = y_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;

`ifdef MFU_OP_COUNT_EN
  logic [15:0] op_count_r;

  // Saturating count of accepted operations, reserved opcodes included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_r <= 16'h0000;
    end else if (in_valid && (op_count_r != 16'hFFFF)) begin
      op_count_r <= op_count_r + 16'h0001;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign op_count = op_count_r;
`endif

endmodule

// File: tb/tb_mfu_logic.sv
// Self-checking bench for mfu_logic: a WIDTH=1 and a WIDTH=8 instance checked against a truth-table model.
module tb_mfu_logic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] sel;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       y1, ov1, err1;
  logic [7:0] y8;
  logic       ov8, err8;
`ifdef MFU_OP_COUNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic       y1_exp  = 1'b0;
  logic [7:0] y8_exp  = 8'h00;
  logic       ov_exp  = 1'b0;
  logic       err_exp = 1'b0;
  int         cnt_exp = 0;

  always #5 clk = ~clk;

  mfu_logic #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .sel(sel),
    .y(y1), .out_valid(ov1), .err(err1)
`ifdef MFU_OP_COUNT_EN
    , .op_count(cnt1)
`endif
  );

  mfu_logic #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .sel(sel),
    .y(y8), .out_valid(ov8), .err(err8)
`ifdef MFU_OP_COUNT_EN
    , .op_count(cnt8)
`endif
  );

  // Truth table per opcode, indexed by {a_bit, b_bit}; reserved opcode yields 0
  function automatic logic [7:0] model_op(input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv);
    logic [3:0] tt [0:7];
    logic [7:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b0110; tt[6] = 4'b1001; tt[7] = 4'b0000;
    for (int i = 0; i < 8; i++) r[i] = tt[s][{av[i], bv[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rv, input logic iv, input logic [2:0] s,
                      input logic ab1, input logic bb1, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] r1;
    rst_n = rv; in_valid = iv; sel = s; a1 = ab1; b1 = bb1; a8 = av; b8 = bv;
    @(posedge clk);
    if (!rv) begin
      y1_exp = 1'b0; y8_exp = 8'h00; ov_exp = 1'b0; err_exp = 1'b0; cnt_exp = 0;
    end else if (iv) begin
      r1      = model_op(s, {7'b0000000, ab1}, {7'b0000000, bb1});
      y1_exp  = r1[0];
      y8_exp  = model_op(s, av, bv);
      ov_exp  = 1'b1;
      err_exp = (s == 3'd7);
      if (cnt_exp < 65535) cnt_exp++;
    end else begin
      ov_exp = 1'b0; err_exp = 1'b0;
    end
    #1;
    chk("y1", {15'd0, y1}, {15'd0, y1_exp});
    chk("ov1", {15'd0, ov1}, {15'd0, ov_exp});
    chk("err1", {15'd0, err1}, {15'd0, err_exp});
    chk("y8", {8'd0, y8}, {8'd0, y8_exp});
    chk("ov8", {15'd0, ov8}, {15'd0, ov_exp});
    chk("err8", {15'd0, err8}, {15'd0, err_exp});
`ifdef MFU_OP_COUNT_EN
    chk("cnt1", cnt1, cnt_exp[15:0]);
    chk("cnt8", cnt8, cnt_exp[15:0]);
`endif
  endtask

  initial begin
    logic [31:0] r;
    int nres;

    // Reset held two cycles with a live operation presented
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 8'hFF, 8'hFF);
      chk("rst_y8", {8'd0, y8}, 16'h0000);
      chk("rst_ov", {15'd0, ov8}, 16'h0000);
    end

    // Exhaustive WIDTH=1 opcode/operand sweep, one result per cycle
    nres = 0;
    for (int s = 0; s < 8; s++) begin
      for (int ab = 0; ab < 4; ab++) begin
        r = $urandom;
        step(1'b1, 1'b1, s[2:0], ab[1], ab[0], r[7:0], r[15:8]);
        if (ov1) nres++;
      end
    end
    chk("n_results", nres[15:0], 16'd32);

    step(1'b1, 1'b1, 3'b011, 1'b1, 1'b1, 8'h00, 8'h00);
    chk("nand11", {15'd0, y1}, 16'h0000);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("not01", {15'd0, y1}, 16'h0001);
    step(1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("rsv_err", {15'd0, err8}, 16'h0001);
    chk("rsv_y8", {8'd0, y8}, 16'h0000);

    // Hold/idle: y keeps last result while out_valid and err stay low
    step(1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 8'h0F, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(1, 0), 8'hAA, 8'h55);
      chk("hold_y1", {15'd0, y1}, 16'h0001);
      chk("hold_ov", {15'd0, ov1}, 16'h0000);
    end

    // Wide operand examples
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 8'hF0, 8'h3C);
    chk("wide_and", {8'd0, y8}, 16'h0030);
    step(1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 8'hF0, 8'h3C);
    chk("wide_nor", {8'd0, y8}, 16'h0003);
    step(1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 8'hF0, 8'h3C);
    chk("wide_xnor", {8'd0, y8}, 16'h0033);

    // Random traffic with idle gaps
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      step(1'b1, r[0] | r[1], r[4:2], r[5], r[6], r[15:8], r[23:16]);
    end

    // Reset in the middle of a continuous stream
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      step(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, r[7:0] | 8'h01, r[15:8]);
    end
    step(1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("midrst_ov", {15'd0, ov8}, 16'h0000);
    chk("midrst_y8", {8'd0, y8}, 16'h0000);
    step(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 8'h81, 8'h18);
    chk("resume_y8", {8'd0, y8}, 16'h0099);
    chk("resume_ov", {15'd0, ov8}, 16'h0001);

`ifdef MFU_OP_COUNT_EN
    // Five accepted ops with idle gaps, one reserved
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, (i == 2) ? 3'b111 : 3'b101, 1'b1, 1'b0, 8'h12, 8'h34);
      step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk("cnt_five", cnt8, 16'd5);

    // Saturation
    for (int i = 0; i < 65540; i++) begin
      r = $urandom;
      step(1'b1, 1'b1, r[2:0], r[3], r[4], r[15:8], r[23:16]);
    end
    chk("cnt_sat", cnt1, 16'hFFFF);
    chk("cnt_sat8", cnt8, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mfu_logic.md
Name: mfu_logic

Overview:
- Registered multi-function logic unit: applies one of seven bitwise Boolean operations to operands a and b, selected by a 3-bit opcode.
- Leaf datapath block for small control/ALU paths; one result per accepted input, one-cycle latency.
- Opcode 3'b111 is reserved: result 0, error flag raised.

Parameters:
- WIDTH, default 1, operand/result width in bits; all operations are bitwise across WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
- in_valid  input  1  a/b/sel valid this cycle; operation accepted when high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sel  input  3  opcode
- y  output  WIDTH  registered result
- out_valid  output  1  high for exactly one cycle per accepted operation
- err  output  1  registered; high with out_valid when the accepted opcode was 3'b111
- op_count  output  16  only when MFU_OP_COUNT_EN is defined (see Optional Feature)

Behaviour:
- Interface is fixed: one clock (clk), synchronous active-low reset (rst_n).
- Reset (rst_n=0 at clk edge): y=0, out_valid=0, err=0, op_count=0. Reset overrides in_valid in the same cycle.
- Opcode map (bitwise, per bit of WIDTH):
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 NOT: ~a (b ignored)
  - 011 NAND: ~(a & b)
  - 100 NOR: ~(a | b)
  - 101 XOR: a ^ b
  - 110 XNOR: ~(a ^ b)
  - 111 reserved: y=0, err=1
- Latency: inputs sampled at edge N with in_valid=1; y/out_valid/err reflect them after edge N, valid during cycle N+1.
- in_valid=0 at an edge: out_valid=0, err=0; y holds its last value.
- Back-to-back: in_valid high on consecutive cycles gives one result per cycle, no bubbles, no stall/ready (always accepts).
- err is 0 whenever out_valid is 0; err=1 only for accepted sel=111.
- X/unknown sel on an accepted cycle: treated as reserved (y=0, err=1). Implement with a default branch.
- No combinational path from inputs to outputs.
- Reset mid-stream: an operation presented in the reset cycle is discarded; no out_valid follows it.

Optional Feature:
- Macro: MFU_OP_COUNT_EN.
- Defined:
  - Port op_count (16 bits) exists; it increments by 1 on every accepted operation (in_valid=1, rst_n=1), including reserved opcodes.
  - It saturates at 16'hFFFF (no wrap) and resets to 0 on rst_n=0.
  - It updates on the same edge as out_valid.
- Not defined: the op_count port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1, sel=001, a=1, b=1 -> y=0, out_valid=0, err=0 throughout; op_count=0.
- Exhaustive (WIDTH=1): for sel=0..7 and {a,b}=00..11, one per cycle with in_valid=1 -> one cycle later y matches the opcode map (e.g. sel=011, a=1, b=1 -> y=0; sel=010, a=0, b=1 -> y=1; sel=110, a=1, b=0 -> y=0). err=1 only for sel=111 (y=0); out_valid=1 every cycle, 32 results total.
- Hold/idle: accept sel=101, a=1, b=0 (y=1), then in_valid=0 for 3 cycles -> y stays 1, out_valid=0, err=0.
- Wide operands (WIDTH=8): sel=000, a=8'hF0, b=8'h3C -> y=8'h30; sel=100, same operands -> y=8'h03; sel=110 -> y=8'h33.
- Reset mid-stream: in_valid=1 continuously, rst_n=0 for one cycle in the middle -> the cycle after reset has out_valid=0, y=0; the next accepted op resumes normally.
- MFU_OP_COUNT_EN: 5 accepted ops with idle gaps, including one sel=111 -> op_count=5. Preload by running 65540 ops -> op_count saturates at 16'hFFFF.
